watch_set_sequencer: RTL and testbench

Sequences time-setting for the watch datapath. It owns the RUN/SET mode and selects the field being edited (hour/min/sec/msec). It converts held up/down buttons into single-cycle inc/dec pulses with auto-repeat, and drives the blink mask for the selected field. It sits between the debounced button/edge detectors and the watch counter datapath, and replaces ad-hoc mode logic.

---
 rtl/watch_set_sequencer_pkg.sv | 35 +++
 rtl/watch_set_sequencer_if.sv | 25 ++
 rtl/watch_set_sequencer_key_repeat.sv | 111 +++++++++++
 rtl/watch_set_sequencer.sv | 119 +++++++++++
 tb/tb_watch_set_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/watch_set_sequencer_pkg.sv
// Shared encodings for the watch time-setting sequencer: field, mode and key states.
package watch_set_pkg;

   typedef logic [1:0] field_t;
   typedef logic [1:0] key_state_t;

   localparam field_t FIELD_MSEC = 2'd0;
   localparam field_t FIELD_SEC  = 2'd1;
   localparam field_t FIELD_MIN  = 2'd2;
   localparam field_t FIELD_HOUR = 2'd3;

   localparam logic [0:0] MODE_RUN = 1'b0;
   localparam logic [0:0] MODE_SET = 1'b1;

   localparam key_state_t K_IDLE   = 2'd0;
   localparam key_state_t K_DELAY  = 2'd1;
   localparam key_state_t K_REPEAT = 2'd2;
   localparam key_state_t K_LOCK   = 2'd3;

   // One counter width shared by all tick counters, sized for the largest terminal count.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

   // Edit order is hour -> min -> sec -> msec -> hour.
   function automatic field_t next_field(input field_t f);
      return f - 2'd1;
   endfunction

endpackage

// File: rtl/watch_set_sequencer_if.sv
// Button/edge inputs and mode/field/pulse outputs of the watch set sequencer.
interface watch_set_sequencer_if;
   logic       i_tick_1ms;
   logic       i_set_toggle;
   logic       i_field_next;
   logic       i_btn_up;
   logic       i_btn_down;
   logic       o_setting;
   logic       o_run;
   logic [1:0] o_field;
   logic [3:0] o_field_onehot;
   logic       o_inc;
   logic       o_dec;
   logic       o_blink;

   modport master (
      output i_tick_1ms, i_set_toggle, i_field_next, i_btn_up, i_btn_down,
      input  o_setting, o_run, o_field, o_field_onehot, o_inc, o_dec, o_blink
   );

   modport slave (
      input  i_tick_1ms, i_set_toggle, i_field_next, i_btn_up, i_btn_down,
      output o_setting, o_run, o_field, o_field_onehot, o_inc, o_dec, o_blink
   );
endinterface

// File: rtl/watch_set_sequencer_key_repeat.sv
// Key FSM: turns held up/down levels into single inc/dec pulses with delayed auto-repeat.
module watch_key_repeat
   import watch_set_pkg::*;
#(
   parameter int REPEAT_DELAY_MS  = 500,
   parameter int REPEAT_PERIOD_MS = 100,
   parameter int CNT_W            = 9
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       active,
   input  logic       tick,
   input  logic       up,
   input  logic       down,
   output logic       inc,
   output logic       dec,
   output key_state_t state
);

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY_MS - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD_MS - 1);

   key_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             dir_reg, dir_next;
   logic             inc_reg, inc_next;
   logic             dec_reg, dec_next;
   logic             pressed, other;
   logic [CNT_W-1:0] last;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      inc_next   = 1'b0;
      dec_next   = 1'b0;
      pressed    = dir_reg ? up : down;
      other      = dir_reg ? down : up;
      last       = (state_reg == K_DELAY) ? DELAY_LAST : PERIOD_LAST;
      if (start) begin
         // Entering SET with a button already down must not produce a pulse.
         state_next = (up || down) ? K_LOCK : K_IDLE;
         cnt_next   = '0;
      end else if (!active) begin
         state_next = K_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            K_IDLE: begin
               cnt_next = '0;
               if (up && down) begin
                  state_next = K_LOCK;
               end else if (up || down) begin
                  state_next = K_DELAY;
                  dir_next   = up;
                  inc_next   = up;
                  dec_next   = down;
               end
            end
            K_DELAY, K_REPEAT: begin
               if (!pressed) begin
                  state_next = K_IDLE;
                  cnt_next   = '0;
               end else if (other) begin
                  state_next = K_LOCK;
                  cnt_next   = '0;
               end else if (tick) begin
                  if (cnt_reg == last) begin
                     state_next = K_REPEAT;
                     cnt_next   = '0;
                     inc_next   = dir_reg;
                     dec_next   = !dir_reg;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
            end
            K_LOCK: begin
               cnt_next = '0;
               if (!up && !down) state_next = K_IDLE;
            end
            default: begin
               state_next = K_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= K_IDLE;
         cnt_reg   <= '0;
         dir_reg   <= 1'b0;
         inc_reg   <= 1'b0;
         dec_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dir_reg   <= dir_next;
         inc_reg   <= inc_next;
         dec_reg   <= dec_next;
      end
   end

   assign inc   = inc_reg;
   assign dec   = dec_reg;
   assign state = state_reg;

endmodule

// File: rtl/watch_set_sequencer.sv
// RUN/SET mode, field select and blink control for the watch; key repeat lives in watch_key_repeat.
// Define SET_TIMEOUT_EN to leave SET automatically after TIMEOUT_MS idle ticks.
module watch_set_sequencer
   import watch_set_pkg::*;
#(
   parameter int REPEAT_DELAY_MS  = 500,
   parameter int REPEAT_PERIOD_MS = 100,
   parameter int BLINK_HALF_MS    = 250,
   parameter int TIMEOUT_MS       = 10000
) (
   input logic                 clk,
   input logic                 reset_n,
   watch_set_sequencer_if.slave bus
);

   localparam int CNT_W = cnt_width(REPEAT_DELAY_MS, REPEAT_PERIOD_MS, BLINK_HALF_MS, TIMEOUT_MS);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF_MS - 1);

   logic [0:0]       mode_reg, mode_next;
   logic             run_reg;
   field_t           field_reg, field_next;
   logic [3:0]       onehot_reg;
   logic             blink_reg;
   logic [CNT_W-1:0] blink_cnt_reg;
   key_state_t       key_state;
   logic             in_set, enter, leave, key_busy, timeout_hit;

   assign in_set   = (mode_reg == MODE_SET);
   assign enter    = !in_set && bus.i_set_toggle;
   // A button seen in K_IDLE is about to leave it, so it already counts as activity.
   assign key_busy = (key_state != K_IDLE) || bus.i_btn_up || bus.i_btn_down;

`ifdef SET_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_MS - 1);
   logic [CNT_W-1:0] idle_cnt_reg;

   assign timeout_hit = in_set && bus.i_tick_1ms && !bus.i_field_next && !key_busy
                        && (idle_cnt_reg == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt_reg <= '0;
      end else if (!in_set || bus.i_field_next || key_busy || timeout_hit) begin
         idle_cnt_reg <= '0;
      end else if (bus.i_tick_1ms) begin
         idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign leave = in_set && (bus.i_set_toggle || timeout_hit);

   always_comb begin
      mode_next  = mode_reg;
      field_next = field_reg;
      if (enter) begin
         mode_next  = MODE_SET;
         field_next = FIELD_HOUR;
      end else if (leave) begin
         mode_next = MODE_RUN;
      end else if (in_set && bus.i_field_next) begin
         field_next = next_field(field_reg);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_reg      <= MODE_RUN;
         run_reg       <= 1'b1;
         field_reg     <= FIELD_HOUR;
         onehot_reg    <= 4'b0000;
         blink_reg     <= 1'b0;
         blink_cnt_reg <= '0;
      end else begin
         mode_reg   <= mode_next;
         run_reg    <= (mode_next == MODE_RUN);
         field_reg  <= field_next;
         onehot_reg <= (mode_next == MODE_SET) ? (4'b0001 << field_next) : 4'b0000;
         // Digits stay lit while adjusting; a field change restarts the blink phase.
         if (!in_set || leave || bus.i_field_next || key_busy) begin
            blink_reg     <= 1'b0;
            blink_cnt_reg <= '0;
         end else if (bus.i_tick_1ms) begin
            if (blink_cnt_reg == BLINK_LAST) begin
               blink_reg     <= !blink_reg;
               blink_cnt_reg <= '0;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + CNT_W'(1);
            end
         end
      end
   end

   watch_key_repeat #(
      .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
      .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS),
      .CNT_W            (CNT_W)
   ) u_key (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (enter),
      .active  (in_set && !leave),
      .tick    (bus.i_tick_1ms),
      .up      (bus.i_btn_up),
      .down    (bus.i_btn_down),
      .inc     (bus.o_inc),
      .dec     (bus.o_dec),
      .state   (key_state)
   );

   assign bus.o_setting      = mode_reg;
   assign bus.o_run          = run_reg;
   assign bus.o_field        = field_reg;
   assign bus.o_field_onehot = onehot_reg;
   assign bus.o_blink        = blink_reg;

endmodule

// File: tb/tb_watch_set_sequencer.sv
// Bench for watch_set_sequencer: tick-level behavioural model checked every cycle, plus directed scenarios.
module tb_watch_set_sequencer;

   localparam int D = 5;
   localparam int P = 2;
   localparam int H = 3;
   localparam int T = 20;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   watch_set_sequencer_if bus ();

   watch_set_sequencer #(
      .REPEAT_DELAY_MS  (D),
      .REPEAT_PERIOD_MS (P),
      .BLINK_HALF_MS    (H),
      .TIMEOUT_MS       (T)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_fail = 0;
   int div = 0;
   int tk = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: elapsed ticks since press / since last activity, evaluated per clock edge.
   bit m_set, m_inc, m_dec, m_blink, m_lock;
   int m_field, m_hold, m_held, m_idle, m_inact;

   always @(posedge clk) begin : model_cmp
      bit st, fn, tkb, up, dn, busy, ex, pr, ot;
      st = bus.i_set_toggle; fn = bus.i_field_next; tkb = bus.i_tick_1ms;
      up = bus.i_btn_up;     dn = bus.i_btn_down;
      m_inc = 0; m_dec = 0;
      if (!reset_n) begin
         m_set = 0; m_field = 3; m_blink = 0; m_lock = 0;
         m_hold = 0; m_held = 0; m_idle = 0; m_inact = 0;
      end else if (!m_set) begin
         m_blink = 0;
         if (st) begin
            m_set = 1; m_field = 3; m_lock = up || dn; m_hold = 0;
            m_idle = 0; m_inact = 0;
         end
      end else begin
         busy = (m_hold != 0) || m_lock || up || dn;
         ex = st;
`ifdef SET_TIMEOUT_EN
         if (fn || busy) m_inact = 0;
         else if (tkb) m_inact++;
         if (m_inact == T) ex = 1;
`endif
         if (ex) begin
            m_set = 0; m_hold = 0; m_lock = 0; m_blink = 0; m_idle = 0; m_inact = 0;
         end else begin
            if (fn) m_field = (m_field + 3) % 4;
            if (fn || busy) begin
               m_idle = 0; m_blink = 0;
            end else if (tkb) begin
               m_idle++;
               m_blink = ((m_idle / H) % 2) == 1;
            end
            if (m_lock) begin
               if (!up && !dn) m_lock = 0;
            end else if (m_hold == 0) begin
               if (up && dn) m_lock = 1;
               else if (up || dn) begin
                  m_hold = up ? 1 : 2; m_held = 0; m_inc = up; m_dec = dn;
               end
            end else begin
               pr = (m_hold == 1) ? up : dn;
               ot = (m_hold == 1) ? dn : up;
               if (!pr) m_hold = 0;
               else if (ot) begin
                  m_hold = 0; m_lock = 1;
               end else if (tkb) begin
                  m_held++;
                  if (m_held == D || (m_held > D && ((m_held - D) % P) == 0)) begin
                     if (m_hold == 1) m_inc = 1; else m_dec = 1;
                  end
               end
            end
         end
      end
      #1;
      chk("setting", bus.o_setting, m_set);
      chk("run", bus.o_run, !m_set);
      chk("field", bus.o_field, m_field);
      chk("onehot", bus.o_field_onehot, m_set ? (1 << m_field) : 0);
      chk("inc", bus.o_inc, m_inc);
      chk("dec", bus.o_dec, m_dec);
      chk("blink", bus.o_blink, m_blink);
   end

   // One clock of stimulus; ticks arrive every 4th cycle.
   task automatic cyc(input bit st, input bit fn);
      bus.i_set_toggle = st;
      bus.i_field_next = fn;
      bus.i_tick_1ms   = (div == 3);
      if (div == 3) tk++;
      div = (div + 1) % 4;
      @(negedge clk);
   endtask

   initial begin
      int exp_f[5];
      int exp_t[5];
      int pt[$];
      int t0, n_inc, n_dec, prev, guard;
      exp_f = '{2, 1, 0, 3, 2};
      exp_t = '{5, 7, 9, 11, 13};
      bus.i_tick_1ms = 0; bus.i_set_toggle = 0; bus.i_field_next = 0;
      bus.i_btn_up = 0;   bus.i_btn_down = 0;
      repeat (3) @(negedge clk);
      chk("rst_setting", bus.o_setting, 0);
      chk("rst_run", bus.o_run, 1);
      chk("rst_field", bus.o_field, 3);
      chk("rst_onehot", bus.o_field_onehot, 0);
      reset_n = 1;

      // Field stepping in SET, frozen in RUN
      cyc(1, 0);
      chk("enter_field", bus.o_field, 3);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1);
         chk("field_step", bus.o_field, exp_f[i]);
      end
      chk("field_onehot", bus.o_field_onehot, 4);
      cyc(1, 0);
      cyc(0, 1);
      chk("field_run_hold", bus.o_field, 2);

      // Hold up for 13 ticks
      cyc(1, 0);
      bus.i_btn_up = 1;
      cyc(0, 0);
      chk("first_inc", bus.o_inc, 1);
      t0 = tk; n_dec = 0;
      while (tk - t0 < 13) begin
         cyc(0, 0);
         if (bus.o_inc) pt.push_back(tk - t0);
         if (bus.o_dec) n_dec++;
      end
      chk("repeat_count", pt.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < pt.size()) chk("repeat_tick", pt[i], exp_t[i]);
      bus.i_btn_up = 0;
      n_inc = 0;
      repeat (12) begin
         cyc(0, 0);
         if (bus.o_inc) n_inc++;
      end
      chk("after_release_inc", n_inc, 0);
      chk("hold_up_dec", n_dec, 0);

      // Reset while auto-repeating
      bus.i_btn_up = 1;
      cyc(0, 0);
      t0 = tk;
      while (tk - t0 < 7) cyc(0, 0);
      reset_n = 0;
      #1;
      chk("midrst_setting", bus.o_setting, 0);
      chk("midrst_run", bus.o_run, 1);
      chk("midrst_field", bus.o_field, 3);
      chk("midrst_inc", bus.o_inc, 0);
      bus.i_tick_1ms = 0;
      @(negedge clk);
      reset_n = 1;
      n_inc = 0;
      repeat (12) begin cyc(0, 0); if (bus.o_inc) n_inc++; end
      cyc(1, 0);
      repeat (30) begin cyc(0, 0); if (bus.o_inc) n_inc++; end
      chk("midrst_no_pulse", n_inc, 0);
      bus.i_btn_up = 0;
      cyc(0, 0);
      bus.i_btn_up = 1;
      cyc(0, 0);
      chk("fresh_press_inc", bus.o_inc, 1);
      bus.i_btn_up = 0;
      cyc(0, 0);

      // Down then up -> lock
      bus.i_btn_down = 1;
      cyc(0, 0);
      chk("lock_dec", bus.o_dec, 1);
      n_inc = 0; n_dec = 0; t0 = tk;
      while (tk - t0 < 2) begin
         cyc(0, 0); if (bus.o_inc) n_inc++; if (bus.o_dec) n_dec++;
      end
      bus.i_btn_up = 1;
      t0 = tk;
      while (tk - t0 < 10) begin
         cyc(0, 0); if (bus.o_inc) n_inc++; if (bus.o_dec) n_dec++;
      end
      bus.i_btn_up = 0;
      repeat (8) begin cyc(0, 0); if (bus.o_inc) n_inc++; if (bus.o_dec) n_dec++; end
      chk("lock_pulses", n_inc + n_dec, 0);
      bus.i_btn_down = 0;
      cyc(0, 0);
      bus.i_btn_up = 1;
      cyc(0, 0);
      chk("unlock_inc", bus.o_inc, 1);
      n_inc = 0;
      repeat (3) begin cyc(0, 0); if (bus.o_inc) n_inc++; end
      bus.i_btn_up = 0;
      repeat (3) begin cyc(0, 0); if (bus.o_inc) n_inc++; end
      chk("unlock_single", n_inc, 0);

      // Blink phases
      cyc(1, 0);
      cyc(1, 0);
      t0 = tk; prev = bus.o_blink; pt.delete();
      while (tk - t0 < 9) begin
         cyc(0, 0);
         if (bus.o_blink != prev) pt.push_back(tk - t0);
         prev = bus.o_blink;
      end
      chk("blink_toggles", pt.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < pt.size()) chk("blink_tick", pt[i], 3 * (i + 1));
      chk("blink_level", bus.o_blink, 1);
      bus.i_btn_up = 1;
      cyc(0, 0);
      chk("blink_press", bus.o_blink, 0);
      bus.i_btn_up = 0;
      cyc(0, 0);
      t0 = tk; guard = 0;
      while (bus.o_blink == 0 && guard < 200) begin cyc(0, 0); guard++; end
      chk("blink_after_release", tk - t0, 3);

`ifdef SET_TIMEOUT_EN
      cyc(1, 0);
      cyc(1, 0);
      t0 = tk; guard = 0;
      while (bus.o_setting && guard < 1000) begin cyc(0, 0); guard++; end
      chk("timeout_tick", tk - t0, 20);
      chk("timeout_run", bus.o_run, 1);
      cyc(1, 0);
      t0 = tk;
      while (tk - t0 < 15) cyc(0, 0);
      cyc(0, 1);
      guard = 0;
      while (bus.o_setting && guard < 1000) begin cyc(0, 0); guard++; end
      chk("timeout_deferred", tk - t0, 35);
`endif

      repeat (4) cyc(0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
